fpu_cmd_issuer: RTL

Initiator-side RTL controller that drives the fpu start/cmd_end protocol on behalf of the CPU datapath. It queues operand/operation commands in a small FIFO and issues them one at a time to the fpu. Each result is captured on completion and returned through a valid/ready result port. It sits between the microcode-controlled register file and the fpu instance.

---
 rtl/fpu_cmd_issuer_pkg.sv | 27 ++
 rtl/fpu_cmd_issuer_fifo.sv | 58 +++++
 rtl/fpu_cmd_issuer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_cmd_issuer_pkg.sv
// Shared types for the fpu command issuer: op encoding, command bundle,
// issuer FSM states and the canonical quiet NaN.
package pa_fpu;

    typedef enum logic [1:0] {
        op_add,
        op_sub,
        op_mul,
        op_div
    } e_fpu_op;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        e_fpu_op     op;
    } st_fpu_cmd;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_RELEASE
    } e_iss_state;

    localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

endpackage

// File: rtl/fpu_cmd_issuer_fifo.sv
// Synchronous command FIFO (fpu_cmd_fifo) with occupancy count.
// Depth must be a power of two; pointers wrap naturally.
module fpu_cmd_fifo
    import pa_fpu::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        push_i,
    input  st_fpu_cmd                   data_i,
    input  logic                        pop_i,
    output st_fpu_cmd                   data_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    st_fpu_cmd     mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Queues fpu commands and drives the start/cmd_end handshake one op at a time.
// Optional FPU_TIMEOUT_EN adds a per-op watchdog that returns a flagged qNaN.
module fpu_cmd_issuer
    import pa_fpu::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  e_fpu_op     cmd_op,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        fpu_start,
    output logic [31:0] fpu_a_operand,
    output logic [31:0] fpu_b_operand,
    output e_fpu_op     fpu_operation,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy,
    input  logic [31:0] ieee_packet_in,
    output logic        issuer_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    e_iss_state    state_q, state_d;
    st_fpu_cmd     wr_cmd;
    st_fpu_cmd     head;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;

    logic          start_q, start_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    e_fpu_op       op_q, op_d;
    logic [31:0]   res_q, res_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
    logic          cmd_end_q;
    logic          end_rise;
    logic          timeout;

    assign wr_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign push   = cmd_valid && cmd_ready;

    fpu_cmd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .push_i  (push),
        .data_i  (wr_cmd),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign end_rise = fpu_cmd_end && !cmd_end_q;

`ifdef FPU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;

    // Held at zero outside ISSUE, so every issued op starts a fresh count.
    always_ff @(posedge clk) begin
        if (arst || state_q != S_ISSUE) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    assign timeout = (state_q == S_ISSUE) && (to_cnt_q == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= op_add;
            res_q     <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            cmd_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_q     <= res_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            cmd_end_q <= fpu_cmd_end;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        vld_d   = vld_q;
        err_d   = err_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    a_d     = head.a;
                    b_d     = head.b;
                    op_d    = head.op;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A real completion wins over a watchdog expiring the same cycle.
                if (end_rise) begin
                    res_d   = ieee_packet_in;
                    err_d   = 1'b0;
                    start_d = 1'b0;
                    vld_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (timeout) begin
                    res_d   = FPU_QNAN;
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    vld_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!fpu_cmd_end && !fpu_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready     = !fifo_full;
    assign res_valid     = vld_q;
    assign res_data      = res_q;
    assign res_err       = err_q;
    assign fpu_start     = start_q;
    assign fpu_a_operand = a_q;
    assign fpu_b_operand = b_q;
    assign fpu_operation = op_q;
    assign issuer_busy   = (fifo_cnt != '0) || (state_q != S_IDLE);

endmodule
